// File: rtl/alu_result_stage.sv
// Registered two-entry elastic buffer behind the ALU: head plus skid storage,
// flag masking, sticky carry/overflow status and a retired-operation counter.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zero,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic [2:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_overflow,
    output logic [2:0]       out_opcode,
    input  logic             clr_sticky,
    output logic             sticky_carry,
    output logic             sticky_overflow,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
        logic             overflow;
        logic [2:0]       opcode;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t stateQ;
    state_t stateNext;
    entry_t head;
    entry_t skid;
    entry_t incoming;

    logic accept;
    logic retire;
    logic flagsLive;
    logic loadHeadIn;
    logic loadHeadSkid;
    logic loadSkid;

    assign in_ready  = (stateQ != FULL);
    assign out_valid = (stateQ != EMPTY);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    // Carry/overflow only mean something for add and sub; the ALU's own
    // zero flag is not trusted, zero is derived from the stored result.
    always_comb begin
        flagsLive         = (in_opcode == 3'b000) || (in_opcode == 3'b001);
        incoming.result   = in_result;
        incoming.zero     = (in_result == '0);
        incoming.carry    = in_carry && flagsLive;
        incoming.overflow = in_overflow && flagsLive;
        incoming.opcode   = in_opcode;
    end

    always_comb begin
        stateNext    = stateQ;
        loadHeadIn   = 1'b0;
        loadHeadSkid = 1'b0;
        loadSkid     = 1'b0;
        unique case (stateQ)
            EMPTY: begin
                if (accept) begin
                    loadHeadIn = 1'b1;
                    stateNext  = ONE;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    loadHeadIn = 1'b1;
                end else if (accept) begin
                    loadSkid  = 1'b1;
                    stateNext = FULL;
                end else if (retire) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (retire) begin
                    loadHeadSkid = 1'b1;
                    stateNext    = ONE;
                end
            end
            default: begin
                stateNext = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= EMPTY;
        end else begin
            stateQ <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (loadHeadIn) begin
                head <= incoming;
            end else if (loadHeadSkid) begin
                head <= skid;
            end
            if (loadSkid) begin
                skid <= incoming;
            end
        end
    end

    // A flag arriving in the same cycle as a clear survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_carry    <= 1'b0;
            sticky_overflow <= 1'b0;
        end else begin
            sticky_carry    <= (clr_sticky ? 1'b0 : sticky_carry)
                             | (accept && incoming.carry);
            sticky_overflow <= (clr_sticky ? 1'b0 : sticky_overflow)
                             | (accept && incoming.overflow);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (retire) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign out_result   = head.result;
    assign out_zero     = head.zero;
    assign out_carry    = head.carry;
    assign out_overflow = head.overflow;
    assign out_opcode   = head.opcode;

    logic unusedZero;
    assign unusedZero = in_zero;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: streaming, backpressure, flag masking,
// sticky priority, counter wrap (CNT_W = 4) and asynchronous reset while full.
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inResult;
    logic             inZero;
    logic             inCarry;
    logic             inOverflow;
    logic [2:0]       inOpcode;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outResult;
    logic             outZero;
    logic             outCarry;
    logic             outOverflow;
    logic [2:0]       outOpcode;
    logic             clrSticky;
    logic             stickyCarry;
    logic             stickyOverflow;
    logic [CNT_W-1:0] opCount;

    int checks = 0;
    int errors = 0;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (inValid),
        .in_ready       (inReady),
        .in_result      (inResult),
        .in_zero        (inZero),
        .in_carry       (inCarry),
        .in_overflow    (inOverflow),
        .in_opcode      (inOpcode),
        .out_valid      (outValid),
        .out_ready      (outReady),
        .out_result     (outResult),
        .out_zero       (outZero),
        .out_carry      (outCarry),
        .out_overflow   (outOverflow),
        .out_opcode     (outOpcode),
        .clr_sticky     (clrSticky),
        .sticky_carry   (stickyCarry),
        .sticky_overflow(stickyOverflow),
        .op_count       (opCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r,
                         input logic [2:0] op, input logic c,
                         input logic o);
        inValid    = v;
        inResult   = r;
        inOpcode   = op;
        inCarry    = c;
        inOverflow = o;
        inZero     = ~c;
    endtask

    initial begin
        rst       = 1'b1;
        outReady  = 1'b0;
        clrSticky = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        step();
        step();
        check("rst_out_valid", {31'b0, outValid}, 32'd0);
        check("rst_in_ready", {31'b0, inReady}, 32'd1);
        check("rst_out_result", outResult, 32'd0);
        check("rst_flags", {28'b0, outZero, outCarry, outOverflow, 1'b0}, 32'd0);
        check("rst_opcode", {29'b0, outOpcode}, 32'd0);
        check("rst_sticky", {30'b0, stickyCarry, stickyOverflow}, 32'd0);
        check("rst_count", {28'b0, opCount}, 32'd0);
        rst = 1'b0;

        // streaming with out_ready held high
        outReady = 1'b1;
        drive(1'b1, 32'd5, 3'b010, 1'b0, 1'b0);
        step();
        check("s1_valid", {31'b0, outValid}, 32'd1);
        check("s1_result", outResult, 32'd5);
        check("s1_zero", {31'b0, outZero}, 32'd0);
        check("s1_opcode", {29'b0, outOpcode}, 32'd2);
        drive(1'b1, 32'd0, 3'b010, 1'b0, 1'b0);
        step();
        check("s2_result", outResult, 32'd0);
        check("s2_zero", {31'b0, outZero}, 32'd1);
        check("s2_count", {28'b0, opCount}, 32'd1);
        drive(1'b1, 32'hFFFF_FFFF, 3'b010, 1'b0, 1'b0);
        step();
        check("s3_result", outResult, 32'hFFFF_FFFF);
        check("s3_zero", {31'b0, outZero}, 32'd0);
        drive(1'b0, 32'h0, 3'b010, 1'b0, 1'b0);
        step();
        check("s4_valid", {31'b0, outValid}, 32'd0);
        check("s4_count", {28'b0, opCount}, 32'd3);

        // backpressure: A and B absorbed, C held off
        outReady = 1'b0;
        drive(1'b1, 32'h11, 3'b010, 1'b0, 1'b0);
        step();
        check("bp_a_ready", {31'b0, inReady}, 32'd1);
        check("bp_a_head", outResult, 32'h11);
        drive(1'b1, 32'h22, 3'b010, 1'b0, 1'b0);
        step();
        check("bp_full_ready", {31'b0, inReady}, 32'd0);
        check("bp_full_head", outResult, 32'h11);
        drive(1'b1, 32'h33, 3'b010, 1'b0, 1'b0);
        step();
        check("bp_hold_ready", {31'b0, inReady}, 32'd0);
        check("bp_hold_head", outResult, 32'h11);
        check("bp_hold_count", {28'b0, opCount}, 32'd3);
        outReady = 1'b1;
        step();
        check("bp_b_head", outResult, 32'h22);
        check("bp_b_ready", {31'b0, inReady}, 32'd1);
        check("bp_b_count", {28'b0, opCount}, 32'd4);
        step();
        check("bp_c_head", outResult, 32'h33);
        check("bp_c_count", {28'b0, opCount}, 32'd5);
        drive(1'b0, 32'h0, 3'b010, 1'b0, 1'b0);
        step();
        check("bp_drain_valid", {31'b0, outValid}, 32'd0);
        check("bp_drain_count", {28'b0, opCount}, 32'd6);

        // flag masking
        drive(1'b1, 32'd7, 3'b011, 1'b1, 1'b1);
        step();
        check("mask_carry", {31'b0, outCarry}, 32'd0);
        check("mask_ovf", {31'b0, outOverflow}, 32'd0);
        check("mask_sticky", {30'b0, stickyCarry, stickyOverflow}, 32'd0);
        drive(1'b1, 32'd8, 3'b000, 1'b1, 1'b0);
        step();
        check("add_carry", {31'b0, outCarry}, 32'd1);
        check("add_sticky_c", {31'b0, stickyCarry}, 32'd1);
        check("add_sticky_o", {31'b0, stickyOverflow}, 32'd0);
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        step();
        check("mask_count", {28'b0, opCount}, 32'd8);

        // sticky: set wins over simultaneous clear
        drive(1'b1, 32'd9, 3'b001, 1'b0, 1'b1);
        step();
        check("stk_set_o", {31'b0, stickyOverflow}, 32'd1);
        clrSticky = 1'b1;
        step();
        check("stk_pri_o", {31'b0, stickyOverflow}, 32'd1);
        check("stk_pri_c", {31'b0, stickyCarry}, 32'd0);
        drive(1'b0, 32'h0, 3'b001, 1'b0, 1'b0);
        step();
        check("stk_clr_o", {31'b0, stickyOverflow}, 32'd0);
        check("stk_count", {28'b0, opCount}, 32'd10);
        clrSticky = 1'b0;

        // fill to FULL, then asynchronous reset between edges
        outReady = 1'b0;
        drive(1'b1, 32'hA1, 3'b000, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hA2, 3'b000, 1'b1, 1'b0);
        step();
        check("ar_full", {31'b0, inReady}, 32'd0);
        check("ar_sticky_pre", {31'b0, stickyCarry}, 32'd1);
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", {31'b0, outValid}, 32'd0);
        check("ar_ready", {31'b0, inReady}, 32'd1);
        check("ar_count", {28'b0, opCount}, 32'd0);
        check("ar_result", outResult, 32'd0);
        check("ar_sticky", {31'b0, stickyCarry}, 32'd0);
        step();
        rst = 1'b0;

        // 17 retires from zero wraps the 4-bit counter to 1
        outReady = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'(i + 1), 3'b100, 1'b0, 1'b0);
            step();
            check("wrap_head", outResult, 32'(i + 1));
        end
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        step();
        check("wrap_valid", {31'b0, outValid}, 32'd0);
        check("wrap_count", {28'b0, opCount}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
